// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the adapter and colour path.
// The generator drives every signal; consumers only read them.
interface vga_timing_gen_if;
    logic       pix_tick;
    logic [9:0] widthPos;
    logic [9:0] heightPos;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;

    modport master (
        output pix_tick, widthPos, heightPos, hsync, vsync, video_on, frame_start
    );

    modport slave (
        input  pix_tick, widthPos, heightPos, hsync, vsync, video_on, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate prescaler, h/v position counters and the sync/enable
// decodes, all registered from the next counter values so they line up with the counters.
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [3:0] div_cnt;
    logic [3:0] div_nxt;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       tick;
    logic       frame_wrap;
    logic       hsync_r;
    logic       vsync_r;
    logic       video_on_r;
    logic       frame_start_r;

    // With CLK_DIV=1 div_cnt is pinned at 0, so tick stays high even in reset.
    assign tick       = (div_cnt == DIV_LAST);
    assign frame_wrap = tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

    always_comb begin
        div_nxt = tick ? 4'd0 : div_cnt + 4'd1;
        h_nxt   = h_cnt;
        v_nxt   = v_cnt;
        if (tick) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_nxt = h_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt       <= '0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            video_on_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            div_cnt       <= div_nxt;
            h_cnt         <= h_nxt;
            v_cnt         <= v_nxt;
            hsync_r       <= !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
            vsync_r       <= !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
            video_on_r    <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            frame_start_r <= frame_wrap;
        end
    end

    assign vga.pix_tick    = tick;
    assign vga.widthPos    = h_cnt;
    assign vga.heightPos   = v_cnt;
    assign vga.hsync       = hsync_r;
    assign vga.vsync       = vsync_r;
    assign vga.video_on    = video_on_r;
    assign vga.frame_start = frame_start_r;
endmodule
